// File: rtl/fejkon_sysinfo.sv
// System information register block: identity, build hash, scratch, uptime and
// link-status change tracking on a fixed-latency Avalon-MM slave.
// Optional uptime counter is built when FEJKON_SYSINFO_UPTIME_EN is defined.

`ifndef FEJKON_GIT_HASH
`define FEJKON_GIT_HASH 32'h0000_0000
`endif

module fejkon_sysinfo #(
  parameter int FcPorts  = 2,
  parameter int EthPorts = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          mm_address,
  input  logic                mm_read,
  input  logic                mm_write,
  input  logic [31:0]         mm_writedata,
  output logic [31:0]         mm_readdata,
  output logic                mm_readdatavalid,
  input  logic [FcPorts-1:0]  fc_up,
  input  logic [EthPorts-1:0] eth_up
);

  typedef enum logic [2:0] {
    ADDR_ID      = 3'd0,
    ADDR_HASH    = 3'd1,
    ADDR_CONFIG  = 3'd2,
    ADDR_SCRATCH = 3'd3,
    ADDR_UP_LO   = 3'd4,
    ADDR_UP_HI   = 3'd5,
    ADDR_STATUS  = 3'd6,
    ADDR_STICKY  = 3'd7
  } addr_e;

  localparam logic [3:0] EthNib  = 4'(EthPorts);
  localparam logic [3:0] FcNib   = 4'(FcPorts);
  localparam logic [7:0] EthByte = 8'(EthPorts);
  localparam logic [7:0] FcByte  = 8'(FcPorts);

  logic [31:0]         readdata_d, readdata_q;
  logic                readdatavalid_d, readdatavalid_q;
  logic [31:0]         scratch_d, scratch_q;
  logic [FcPorts-1:0]  fc_prev_d, fc_prev_q, fc_sticky_d, fc_sticky_q;
  logic [EthPorts-1:0] eth_prev_d, eth_prev_q, eth_sticky_d, eth_sticky_q;
  logic                armed_d, armed_q;

  logic [31:0] uptime_lo;
  logic [15:0] uptime_hi_shadow;
  logic        uptime_present;
  logic [31:0] rd_word;
  logic [7:0]  fc_live_ext, eth_live_ext, fc_sticky_ext, eth_sticky_ext;
  logic        wr_scratch, wr_clear, rd_up_lo;
  logic        unused_wdata;

  assign wr_scratch   = mm_write && (addr_e'(mm_address) == ADDR_SCRATCH);
  assign wr_clear     = mm_write && (addr_e'(mm_address) == ADDR_STICKY);
  assign rd_up_lo     = mm_read  && (addr_e'(mm_address) == ADDR_UP_LO);
  assign unused_wdata = ^mm_writedata;

`ifdef FEJKON_SYSINFO_UPTIME_EN
  logic [47:0] uptime_d, uptime_q;
  logic [15:0] shadow_d, shadow_q;

  always_comb begin
    uptime_d = uptime_q + 48'd1;
    shadow_d = shadow_q;
    // Shadow the upper half of the very value returned for the low read.
    if (rd_up_lo) shadow_d = uptime_q[47:32];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q <= '0;
      shadow_q <= '0;
    end else begin
      uptime_q <= uptime_d;
      shadow_q <= shadow_d;
    end
  end

  assign uptime_lo        = uptime_q[31:0];
  assign uptime_hi_shadow = shadow_q;
  assign uptime_present   = 1'b1;
`else
  logic unused_up_rd;
  assign unused_up_rd     = rd_up_lo;
  assign uptime_lo        = 32'h0;
  assign uptime_hi_shadow = 16'h0;
  assign uptime_present   = 1'b0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default before any branch, so no latches.
    fc_live_ext    = '0;
    eth_live_ext   = '0;
    fc_sticky_ext  = '0;
    eth_sticky_ext = '0;
    fc_live_ext[FcPorts-1:0]     = fc_up;
    eth_live_ext[EthPorts-1:0]   = eth_up;
    fc_sticky_ext[FcPorts-1:0]   = fc_sticky_q;
    eth_sticky_ext[EthPorts-1:0] = eth_sticky_q;
  end

  always_comb begin
    rd_word = 32'h0;
    case (addr_e'(mm_address))
      ADDR_ID:      rd_word = {EthNib, FcNib, 24'h010DE5};
      ADDR_HASH:    rd_word = `FEJKON_GIT_HASH;
      ADDR_CONFIG:  rd_word = {8'h02, 7'b0, uptime_present, EthByte, FcByte};
      ADDR_SCRATCH: rd_word = scratch_q;
      ADDR_UP_LO:   rd_word = uptime_lo;
      ADDR_UP_HI:   rd_word = {16'h0, uptime_hi_shadow};
      ADDR_STATUS:  rd_word = {16'h0, eth_live_ext, fc_live_ext};
      ADDR_STICKY:  rd_word = {16'h0, eth_sticky_ext, fc_sticky_ext};
      default:      rd_word = 32'h0;
    endcase
  end

  always_comb begin
    readdatavalid_d = mm_read;
    readdata_d      = mm_read ? rd_word : 32'h0;
    scratch_d       = wr_scratch ? mm_writedata : scratch_q;

    fc_prev_d    = fc_up;
    eth_prev_d   = eth_up;
    armed_d      = 1'b1;
    fc_sticky_d  = fc_sticky_q;
    eth_sticky_d = eth_sticky_q;
    if (wr_clear) begin
      fc_sticky_d  = fc_sticky_d  & ~mm_writedata[FcPorts-1:0];
      eth_sticky_d = eth_sticky_d & ~mm_writedata[8 +: EthPorts];
    end
    // Set is applied after clear so a coincident change is never lost; the
    // first cycle out of reset only primes the previous-value register.
    if (armed_q) begin
      fc_sticky_d  = fc_sticky_d  | (fc_up  ^ fc_prev_q);
      eth_sticky_d = eth_sticky_d | (eth_up ^ eth_prev_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      scratch_q       <= '0;
      fc_prev_q       <= '0;
      eth_prev_q      <= '0;
      fc_sticky_q     <= '0;
      eth_sticky_q    <= '0;
      armed_q         <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignment so all read the old values.
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      scratch_q       <= scratch_d;
      fc_prev_q       <= fc_prev_d;
      eth_prev_q      <= eth_prev_d;
      fc_sticky_q     <= fc_sticky_d;
      eth_sticky_q    <= eth_sticky_d;
      armed_q         <= armed_d;
    end
  end

  assign mm_readdata      = readdata_q;
  assign mm_readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_fejkon_sysinfo.sv
// Directed scoreboard bench for fejkon_sysinfo; follows FEJKON_SYSINFO_UPTIME_EN.

`ifndef FEJKON_GIT_HASH
`define FEJKON_GIT_HASH 32'h0000_0000
`endif

module tb_fejkon_sysinfo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  mm_address;
  logic        mm_read;
  logic        mm_write;
  logic [31:0] mm_writedata;
  logic [31:0] mm_readdata;
  logic        mm_readdatavalid;
  logic [1:0]  fc_up;
  logic [1:0]  eth_up;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  logic [31:0] sb[$];
  logic [47:0] up_m;
  logic        freeze_up = 1'b0;

  fejkon_sysinfo #(.FcPorts(2), .EthPorts(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mm_address       (mm_address),
    .mm_read          (mm_read),
    .mm_write         (mm_write),
    .mm_writedata     (mm_writedata),
    .mm_readdata      (mm_readdata),
    .mm_readdatavalid (mm_readdatavalid),
    .fc_up            (fc_up),
    .eth_up           (eth_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, push the expected read word, clock, then compare.
  task automatic step(input logic rd, input logic wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    mm_read      = rd;
    mm_write     = wr;
    mm_address   = a;
    mm_writedata = wd;
    if (rd && reset_n) sb.push_back(exp);
    @(posedge clk);
    #1;
    if (reset_n && !freeze_up) up_m = up_m + 48'd1;
    freeze_up = 1'b0;
    mm_read  = 1'b0;
    mm_write = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_valid"}, {31'h0, mm_readdatavalid}, 32'h1);
      check(tag, mm_readdata, e);
    end else begin
      check({tag, "_novalid"}, {31'h0, mm_readdatavalid}, 32'h0);
      check({tag, "_zero"}, mm_readdata, 32'h0);
    end
  endtask

  function automatic logic [31:0] fresh_word(input int a);
    case (a)
      0: return 32'h2201_0DE5;
      1: return `FEJKON_GIT_HASH;
`ifdef FEJKON_SYSINFO_UPTIME_EN
      2: return 32'h0201_0202;
      4: return up_m[31:0];
`else
      2: return 32'h0200_0202;
      4: return 32'h0;
`endif
      6: return 32'h0000_0201;  // eth_up=10, fc_up=01
      default: return 32'h0;    // scratch, shadow and sticky all clear
    endcase
  endfunction

  initial begin
    reset_n      = 1'b0;
    mm_read      = 1'b0;
    mm_write     = 1'b0;
    mm_address   = 3'd0;
    mm_writedata = 32'h0;
    fc_up        = 2'b01;
    eth_up       = 2'b10;
    up_m         = 48'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, mm_readdatavalid}, 32'h0);
    check("rst_data", mm_readdata, 32'h0);
    reset_n = 1'b1;

    // Back-to-back reads every cycle, also proves no sticky bit from reset release.
    for (int a = 0; a < 8; a++)
      step(1'b1, 1'b0, 3'(a), 32'h0, fresh_word(a), $sformatf("b2b_a%0d", a));

    step(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 32'h0, "wr_scratch");
    step(1'b1, 1'b0, 3'd3, 32'h0, 32'hDEAD_BEEF, "rd_scratch");
    step(1'b1, 1'b1, 3'd3, 32'h1234_5678, 32'hDEAD_BEEF, "rdwr_prewrite");
    step(1'b1, 1'b0, 3'd3, 32'h0, 32'h1234_5678, "rd_after_rdwr");
    step(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0, "wr_ro_id");
    step(1'b1, 1'b0, 3'd0, 32'h0, 32'h2201_0DE5, "rd_ro_id");

    fc_up = 2'b11;
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, "fc1_rise");
    step(1'b1, 1'b0, 3'd7, 32'h0, 32'h0000_0002, "sticky_fc1");
    fc_up = 2'b01;
    step(1'b0, 1'b1, 3'd7, 32'h0000_0002, 32'h0, "clr_vs_set");
    step(1'b1, 1'b0, 3'd7, 32'h0, 32'h0000_0002, "sticky_set_wins");
    step(1'b0, 1'b1, 3'd7, 32'h0000_0002, 32'h0, "clr_fc1");
    step(1'b1, 1'b0, 3'd7, 32'h0, 32'h0000_0000, "sticky_cleared");
    eth_up = 2'b00;
    step(1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0, "eth1_fall_wr_ro");
    step(1'b1, 1'b0, 3'd7, 32'h0, 32'h0000_0200, "sticky_eth1");
    step(1'b1, 1'b0, 3'd6, 32'h0, 32'h0000_0001, "live_status");
    step(1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, "clr_all");
    step(1'b1, 1'b0, 3'd7, 32'h0, 32'h0000_0000, "sticky_all_clear");

`ifdef FEJKON_SYSINFO_UPTIME_EN
    force dut.uptime_q = 48'h0000_FFFF_FFFF;
    up_m      = 48'h0000_FFFF_FFFF;
    freeze_up = 1'b1;
    step(1'b1, 1'b0, 3'd4, 32'h0, 32'hFFFF_FFFF, "up_lo_forced");
    release dut.uptime_q;
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, "up_idle");
    step(1'b1, 1'b0, 3'd5, 32'h0, 32'h0000_0000, "up_hi_coherent");
    step(1'b1, 1'b0, 3'd4, 32'h0, up_m[31:0], "up_lo_wrapped");
    step(1'b1, 1'b0, 3'd5, 32'h0, 32'h0000_0001, "up_hi_shadow1");
`else
    step(1'b1, 1'b0, 3'd4, 32'h0, 32'h0, "up_lo_absent");
    step(1'b1, 1'b0, 3'd5, 32'h0, 32'h0, "up_hi_absent");
`endif

    // Reset asserted mid-cycle while a read is being presented.
    mm_read    = 1'b1;
    mm_address = 3'd3;
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("inflight_valid", {31'h0, mm_readdatavalid}, 32'h0);
    check("inflight_data", mm_readdata, 32'h0);
    mm_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    up_m    = 48'h0;
    step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, "post_rst_idle");
    step(1'b1, 1'b0, 3'd3, 32'h0, 32'h0000_0000, "scratch_after_rst");
    step(1'b1, 1'b0, 3'd7, 32'h0, 32'h0000_0000, "sticky_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
